sdram_wr_ctrl: RTL
==================

Name: sdram_wr_ctrl

Overview:
Camera-to-SDRAM write-side burst controller. It sits downstream of the camera capture stage, which writes 16-bit pixels into an async FIFO. The controller runs in the SDRAM clock domain on the FIFO read side. It waits until a full burst is buffered, requests the SDRAM write arbiter, streams exactly BURST_LEN words to the SDRAM write engine, then advances a linear frame address that wraps at the frame size.

Parameters:
BURST_LEN, 64, words per SDRAM write burst; power of two.
FRAME_WORDS, 307200, words per frame (640x480); must be a multiple of BURST_LEN.
ADDR_W, 22, width of the linear word address.
CNT_W, 10, width of the FIFO read-side word count.

Ports:
sclk  in  1  SDRAM-domain clock; the only clock.
s_rst_n  in  1  reset; synchronous, active-low.
frame_start  in  1  single-cycle pulse, vsync edge already synchronised to sclk.
fifo_rd_cnt  in  CNT_W  words currently readable from the FIFO.
fifo_rd_data  in  16  FIFO read data; valid 1 cycle after fifo_rd_en.
fifo_rd_en  out  1  FIFO read strobe.
wr_req  out  1  write request to the SDRAM arbiter.
wr_grant  in  1  arbiter grant; single-cycle pulse.
wr_data_req  in  1  SDRAM write engine requests one word per high cycle.
wr_end  in  1  SDRAM write engine burst-complete pulse.
wr_addr  out  ADDR_W  burst start word address.
wr_data  out  16  data to the SDRAM write engine.
frame_done  out  1  single-cycle pulse when the last burst of a frame completes.

Behaviour:
- Reset (s_rst_n low at a sclk edge) forces the following on that edge, including mid-burst:
  - state=IDLE, armed=0, pend_sof=0, word_cnt=0.
  - wr_req=0, fifo_rd_en=0, wr_addr=0, frame_done=0.
- armed: set by the first frame_start after reset. While armed=0, no request is made, so writing always begins frame-aligned.
- FSM states and transitions:
  - IDLE -> REQ when armed=1 and fifo_rd_cnt >= BURST_LEN. wr_req is registered and goes high on that transition edge.
  - REQ: wr_req held high. On wr_grant -> BURST; wr_req drops on the same edge.
  - BURST:
    - fifo_rd_en = wr_data_req AND (word_cnt < BURST_LEN), combinational.
    - word_cnt increments on each such cycle.
    - wr_data = fifo_rd_data as a combinational pass-through, so the write engine samples data 1 cycle after its request.
    - Requests beyond BURST_LEN are ignored; the FIFO is never over-read.
    - On wr_end -> DONE.
  - DONE (1 cycle): update the address, clear word_cnt, -> IDLE. Back-to-back bursts therefore have 2 idle cycles before the next wr_req.
- Address update in DONE:
  - if pend_sof=1: wr_addr <= 0, pend_sof <= 0, no frame_done.
  - else if wr_addr + BURST_LEN == FRAME_WORDS: wr_addr <= 0 and frame_done pulses high for exactly this 1 cycle.
  - else: wr_addr <= wr_addr + BURST_LEN.
- frame_start handling:
  - In IDLE or REQ: wr_addr <= 0 on the next edge. A pending request stays pending and is not withdrawn.
  - In BURST or DONE: set pend_sof; the address is not changed mid-burst, so the burst in flight completes at its original address.
  - The first frame_start after reset only arms the block; wr_addr is already 0.
- wr_addr is stable from REQ entry through wr_end.
- Simultaneous frame_start and wr_end in BURST: pend_sof is set, so the DONE update takes the pend_sof branch and wr_addr goes to 0.
- wr_end before BURST_LEN words have been read: still -> DONE and the address advances. The lost words are the write engine's fault and are not re-read.

Test Plan:
- Reset, then frame_start, then fifo_rd_cnt=64 -> wr_req rises 1 cycle after fifo_rd_cnt>=64; wr_addr=0; no wr_req if frame_start is withheld.
- Grant then 70 wr_data_req cycles -> exactly 64 fifo_rd_en pulses; wr_data matches fifo_rd_data sequence 0..63; after wr_end, wr_addr=64.
- FRAME_WORDS=256, BURST_LEN=64, 4 bursts -> wr_addr 0, 64, 128, 192, then 0; frame_done pulses once, 1 cycle after the 4th wr_end.
- frame_start mid-burst at wr_addr=128 -> burst completes at 128; next wr_addr=0; no frame_done.
- frame_start in REQ with wr_addr=192 -> wr_addr=0 on next edge, wr_req stays high, burst goes to 0.
- s_rst_n low during BURST word 30 -> next edge: all outputs 0, state IDLE, armed=0; no request until a new frame_start.

Source files
------------

// File: rtl/sdram_wr_ctrl.sv
// rtl/sdram_wr_ctrl.sv - camera-to-SDRAM write-side burst controller
//
// Waits for a full burst in the capture FIFO, requests the SDRAM write
// arbiter, streams BURST_LEN words to the write engine and then advances a
// linear frame address that wraps at FRAME_WORDS.
//
// Ports:
//   sclk          SDRAM-domain clock (only clock)
//   s_rst_n       synchronous active-low reset
//   frame_start   single-cycle vsync pulse, already in the sclk domain
//   fifo_rd_cnt   words readable from the capture FIFO
//   fifo_rd_data  FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en    FIFO read strobe
//   wr_req        write request to the SDRAM arbiter
//   wr_grant      arbiter grant pulse
//   wr_data_req   write engine asks for one word per high cycle
//   wr_end        write engine burst-complete pulse
//   wr_addr       burst start word address
//   wr_data       data to the write engine
//   frame_done    pulse when the last burst of a frame completes
module sdram_wr_ctrl #(
    parameter int BURST_LEN   = 64,
    parameter int FRAME_WORDS = 307200,
    parameter int ADDR_W      = 22,
    parameter int CNT_W       = 10
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  fifo_rd_cnt,
    input  logic [15:0]       fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              wr_req,
    input  logic              wr_grant,
    input  logic              wr_data_req,
    input  logic              wr_end,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done
);

    localparam int WC_W = $clog2(BURST_LEN) + 1;
    localparam logic [WC_W-1:0]   BURST_CNT  = WC_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  BURST_FILL = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    // wr_addr + BURST_LEN == FRAME_WORDS, rearranged so the sum cannot overflow
    localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(FRAME_WORDS - BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic            armed;
    logic            pend_sof;
    logic [WC_W-1:0] word_cnt;

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (armed && fifo_rd_cnt >= BURST_FILL) next_state = REQ;
            REQ:     if (wr_grant) next_state = BURST;
            BURST:   if (wr_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // wr_req is a decode of the state register, so it rises on the IDLE->REQ
    // edge and falls on the grant edge without any combinational input path.
    // Read strobes past BURST_LEN are swallowed so the FIFO is never over-read.
    always_comb begin
        wr_req     = (state == REQ);
        fifo_rd_en = (state == BURST) && wr_data_req && (word_cnt < BURST_CNT);
    end

    // FIFO data is one cycle behind the strobe, which is exactly the write
    // engine's sampling latency, so the data passes straight through.
    assign wr_data = fifo_rd_data;

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            armed      <= 1'b0;
            pend_sof   <= 1'b0;
            word_cnt   <= '0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (fifo_rd_en) begin
                word_cnt <= word_cnt + WC_W'(1);
            end

            if (state == DONE) begin
                word_cnt <= '0;
                if (pend_sof) begin
                    wr_addr  <= '0;
                    pend_sof <= 1'b0;
                end else if (wr_addr == FRAME_LAST) begin
                    wr_addr    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + BURST_STEP;
                end
            end

            // Placed last so a frame_start landing in DONE re-arms pend_sof
            // rather than being lost to the clear above.
            if (frame_start) begin
                if (!armed) begin
                    armed <= 1'b1;
                end else if (state == IDLE || state == REQ) begin
                    wr_addr <= '0;
                end else begin
                    pend_sof <= 1'b1;
                end
            end
        end
    end

endmodule
